// File: rtl/smp_resv_req_if.sv
// smp_resv_req_if: core-side and fabric-side handshake bundle for the SMP
// larx/stcx reservation initiator.
//   core_*  : request (val/tid/op/ra), per-thread flush, per-thread ready
//   req_*   : fabric request, held until req_ack
//   rsp_*   : stcx pass/fail response from the fabric
//   cmp_*   : per-thread completion back to the core
//   err     : sticky protocol error
// master = the initiator block, slave = core + fabric environment.
interface smp_resv_req_if #(parameter int THREADS = 4);
  localparam int TW = $clog2(THREADS);

  logic               core_val;
  logic [TW-1:0]      core_tid;
  logic               core_op;
  logic [31:0]        core_ra;
  logic [THREADS-1:0] core_rdy;
  logic [THREADS-1:0] core_flush;

  logic               req_val;
  logic [TW-1:0]      req_tid;
  logic               req_op;
  logic [26:0]        req_ra;
  logic               req_ack;

  logic               rsp_val;
  logic [TW-1:0]      rsp_tid;
  logic               rsp_pass;

  logic               cmp_val;
  logic [TW-1:0]      cmp_tid;
  logic               cmp_op;
  logic               cmp_pass;

  logic               err;

  modport master (
    input  core_val, core_tid, core_op, core_ra, core_flush,
           req_ack, rsp_val, rsp_tid, rsp_pass,
    output core_rdy, req_val, req_tid, req_op, req_ra,
           cmp_val, cmp_tid, cmp_op, cmp_pass, err
  );

  modport slave (
    output core_val, core_tid, core_op, core_ra, core_flush,
           req_ack, rsp_val, rsp_tid, rsp_pass,
    input  core_rdy, req_val, req_tid, req_op, req_ra,
           cmp_val, cmp_tid, cmp_op, cmp_pass, err
  );
endinterface

// File: rtl/smp_resv_req.sv
// smp_resv_req: core-side initiator for SMP larx/stcx reservations.
// Tracks one operation per thread (IDLE/REQ/WAIT/DONE), issues REQ threads
// to the fabric round-robin, collects stcx results and returns completions
// lowest-tid first.
//   clk, rst : clock, async active-low reset
//   bus      : smp_resv_req_if.master (core, fabric request/response, cmp, err)
// All outputs decode from registered state only.

// Per-thread operation tracker. Qualified events come from the top.
module smp_resv_thr (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc,      // accept while IDLE
  input  logic        op_in,
  input  logic [26:0] ra_in,
  input  logic        ack,      // this thread acked on the fabric
  input  logic        flush,    // flush, already excluding the presented thread
  input  logic        rsp,      // stcx response while WAIT
  input  logic        pass_in,
  input  logic        cmp_take, // this thread drives cmp_* this cycle
  output logic        st_idle,
  output logic        st_req,
  output logic        st_wait,
  output logic        st_done,
  output logic        op,
  output logic [26:0] ra,
  output logic        pass
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} st_e;
  st_e st, st_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= IDLE;
      op   <= 1'b0;
      ra   <= '0;
      pass <= 1'b0;
    end else begin
      st <= st_nxt;
      if (acc) begin
        op   <= op_in;
        ra   <= ra_in;
        pass <= 1'b0;  // larx always completes with pass=0
      end
      if (rsp) pass <= pass_in;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: if (acc) st_nxt = REQ;
      REQ:  if (ack) st_nxt = op ? WAIT : DONE;
            else if (flush) st_nxt = IDLE;
      WAIT: if (rsp) st_nxt = DONE;
      DONE: if (cmp_take) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  assign st_idle = (st == IDLE);
  assign st_req  = (st == REQ);
  assign st_wait = (st == WAIT);
  assign st_done = (st == DONE);
endmodule

module smp_resv_req #(parameter int THREADS = 4) (
  input  logic           clk,
  input  logic           rst,
  smp_resv_req_if.master bus
);
  localparam int TW = $clog2(THREADS);

  logic [THREADS-1:0]       s_idle, s_req, s_wait, s_done, t_op, t_pass;
  logic [THREADS-1:0][26:0] t_ra;

  logic          pres_vld;   // a request is on req_* and not yet acked
  logic [TW-1:0] pres_tid;
  logic [TW-1:0] rr_ptr;
  logic          err_q;

  logic          pick_vld, req_val, ack_q, cmp_val;
  logic [TW-1:0] pick_tid, req_tid, cmp_tid, idx;

  logic unused_ra_lo;
  assign unused_ra_lo = ^bus.core_ra[4:0];

  // Round-robin search starting at rr_ptr; first REQ thread wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_tid = '0;
    idx      = '0;
    for (int i = 0; i < THREADS; i++) begin
      idx = rr_ptr + TW'(i);
      if (!pick_vld && s_req[idx]) begin
        pick_vld = 1'b1;
        pick_tid = idx;
      end
    end
  end

  // Presented request is frozen until acked.
  assign req_val = pres_vld | pick_vld;
  assign req_tid = pres_vld ? pres_tid : pick_tid;
  assign ack_q   = bus.req_ack & req_val;

  // Lowest-numbered DONE thread completes.
  always_comb begin
    cmp_val = 1'b0;
    cmp_tid = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (s_done[i]) begin
        cmp_val = 1'b1;
        cmp_tid = TW'(i);
      end
    end
  end

  for (genvar t = 0; t < THREADS; t++) begin : g_thr
    smp_resv_thr u_thr (
      .clk      (clk),
      .rst      (rst),
      .acc      (bus.core_val && bus.core_tid == TW'(t) && s_idle[t]),
      .op_in    (bus.core_op),
      .ra_in    (bus.core_ra[31:5]),
      .ack      (ack_q && req_tid == TW'(t)),
      .flush    (bus.core_flush[t] && !(req_val && req_tid == TW'(t))),
      .rsp      (bus.rsp_val && bus.rsp_tid == TW'(t) && s_wait[t]),
      .pass_in  (bus.rsp_pass),
      .cmp_take (cmp_val && cmp_tid == TW'(t)),
      .st_idle  (s_idle[t]),
      .st_req   (s_req[t]),
      .st_wait  (s_wait[t]),
      .st_done  (s_done[t]),
      .op       (t_op[t]),
      .ra       (t_ra[t]),
      .pass     (t_pass[t])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pres_vld <= 1'b0;
      pres_tid <= '0;
      rr_ptr   <= '0;
      err_q    <= 1'b0;
    end else begin
      pres_vld <= req_val & ~bus.req_ack;
      pres_tid <= req_tid;
      if (ack_q) rr_ptr <= req_tid + 1'b1;
      // Dropped request to a busy thread, or response to a thread not in WAIT.
      if ((bus.core_val && !s_idle[bus.core_tid]) ||
          (bus.rsp_val && !s_wait[bus.rsp_tid]))
        err_q <= 1'b1;
    end
  end

  assign bus.core_rdy = s_idle;
  assign bus.req_val  = req_val;
  assign bus.req_tid  = req_tid;
  assign bus.req_op   = req_val & t_op[req_tid];
  assign bus.req_ra   = req_val ? t_ra[req_tid] : '0;
  assign bus.cmp_val  = cmp_val;
  assign bus.cmp_tid  = cmp_tid;
  assign bus.cmp_op   = cmp_val & t_op[cmp_tid];
  assign bus.cmp_pass = cmp_val & t_pass[cmp_tid];
  assign bus.err      = err_q;
endmodule

// File: tb/tb_smp_resv_req.sv
// Directed bench for smp_resv_req: reset values, larx/stcx latency,
// round-robin, flush, completion ordering and error cases.
module tb_smp_resv_req;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  smp_resv_req_if #(.THREADS(4)) bus ();
  smp_resv_req #(.THREADS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs and samples both land 1ns after the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic [1:0] tid, input logic op, input logic [31:0] ra);
    bus.core_val = 1'b1;
    bus.core_tid = tid;
    bus.core_op  = op;
    bus.core_ra  = ra;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_rdy"},  32'(bus.core_rdy), 32'hf);
    chk({tag, "_rval"}, 32'(bus.req_val), 32'h0);
    chk({tag, "_rtid"}, 32'(bus.req_tid), 32'h0);
    chk({tag, "_rop"},  32'(bus.req_op), 32'h0);
    chk({tag, "_rra"},  32'(bus.req_ra), 32'h0);
    chk({tag, "_cval"}, 32'(bus.cmp_val), 32'h0);
    chk({tag, "_ctid"}, 32'(bus.cmp_tid), 32'h0);
    chk({tag, "_cop"},  32'(bus.cmp_op), 32'h0);
    chk({tag, "_cpass"},32'(bus.cmp_pass), 32'h0);
  endtask

  initial begin
    bus.core_val = 0; bus.core_tid = 0; bus.core_op = 0; bus.core_ra = 0;
    bus.core_flush = 0; bus.req_ack = 0;
    bus.rsp_val = 0; bus.rsp_tid = 0; bus.rsp_pass = 0;

    // Reset values
    #3;
    chk_idle_outs("rst");
    chk("rst_err", 32'(bus.err), 32'h0);
    step; step;
    rst = 1'b1;

    // larx tid1, immediate ack
    core(2'd1, 1'b0, 32'h0000_1040);
    step; bus.core_val = 0;
    chk("lx_rval", 32'(bus.req_val), 32'h1);
    chk("lx_rtid", 32'(bus.req_tid), 32'h1);
    chk("lx_rop",  32'(bus.req_op), 32'h0);
    chk("lx_rra",  32'(bus.req_ra), 32'h82);
    chk("lx_rdy",  32'(bus.core_rdy), 32'hd);
    bus.req_ack = 1;
    step; bus.req_ack = 0;
    chk("lx_cval", 32'(bus.cmp_val), 32'h1);
    chk("lx_ctid", 32'(bus.cmp_tid), 32'h1);
    chk("lx_cop",  32'(bus.cmp_op), 32'h0);
    chk("lx_cpass",32'(bus.cmp_pass), 32'h0);
    chk("lx_rval2",32'(bus.req_val), 32'h0);
    step;
    chk_idle_outs("lx_end");

    // stcx tid2, ack cycle 1, rsp pass=1 at cycle 4
    core(2'd2, 1'b1, 32'h0000_2000);
    step; bus.core_val = 0;
    chk("sx_rtid", 32'(bus.req_tid), 32'h2);
    chk("sx_rop",  32'(bus.req_op), 32'h1);
    chk("sx_rdy1", 32'(bus.core_rdy[2]), 32'h0);
    bus.req_ack = 1;
    step; bus.req_ack = 0;
    chk("sx_rval2", 32'(bus.req_val), 32'h0);
    chk("sx_cval2", 32'(bus.cmp_val), 32'h0);
    chk("sx_rdy2",  32'(bus.core_rdy[2]), 32'h0);
    step;
    chk("sx_rdy3",  32'(bus.core_rdy[2]), 32'h0);
    step;
    chk("sx_rdy4",  32'(bus.core_rdy[2]), 32'h0);
    chk("sx_cval4", 32'(bus.cmp_val), 32'h0);
    bus.rsp_val = 1; bus.rsp_tid = 2; bus.rsp_pass = 1;
    step; bus.rsp_val = 0; bus.rsp_pass = 0;
    chk("sx_cval", 32'(bus.cmp_val), 32'h1);
    chk("sx_ctid", 32'(bus.cmp_tid), 32'h2);
    chk("sx_cop",  32'(bus.cmp_op), 32'h1);
    chk("sx_cpass",32'(bus.cmp_pass), 32'h1);
    chk("sx_rdy5", 32'(bus.core_rdy[2]), 32'h0);
    step;
    chk("sx_rdy6", 32'(bus.core_rdy[2]), 32'h1);
    chk("sx_cval6",32'(bus.cmp_val), 32'h0);
    chk("sx_err",  32'(bus.err), 32'h0);

    // Round-robin: larx t0..t3, ack held 0 for cycles 1-5
    core(2'd0, 1'b0, 32'h0000_0100);
    step; core(2'd1, 1'b0, 32'h0000_0200);
    chk("rr_c1", 32'(bus.req_tid), 32'h0);
    step; core(2'd2, 1'b0, 32'h0000_0300);
    chk("rr_c2", 32'(bus.req_tid), 32'h0);
    step; core(2'd3, 1'b0, 32'h0000_0400);
    chk("rr_c3", 32'(bus.req_tid), 32'h0);
    step; bus.core_val = 0;
    chk("rr_c4", 32'(bus.req_tid), 32'h0);
    chk("rr_rdy4", 32'(bus.core_rdy), 32'h0);
    step;
    chk("rr_c5", 32'(bus.req_tid), 32'h0);
    chk("rr_ra5", 32'(bus.req_ra), 32'h8);
    step;
    chk("rr_c6", 32'(bus.req_tid), 32'h0);
    chk("rr_v6", 32'(bus.req_val), 32'h1);
    bus.req_ack = 1;
    step;
    chk("rr_c7", 32'(bus.req_tid), 32'h1);
    chk("rr_ra7", 32'(bus.req_ra), 32'h10);
    chk("rr_cmp7", 32'(bus.cmp_tid), 32'h0);
    step;
    chk("rr_c8", 32'(bus.req_tid), 32'h2);
    chk("rr_cmp8", 32'(bus.cmp_tid), 32'h1);
    chk("rr_rdy8", 32'(bus.core_rdy[0]), 32'h1);
    core(2'd0, 1'b0, 32'h0000_0500);
    step; bus.core_val = 0;
    chk("rr_c9", 32'(bus.req_tid), 32'h3);
    chk("rr_cmp9", 32'(bus.cmp_tid), 32'h2);
    step;
    chk("rr_c10", 32'(bus.req_tid), 32'h0);
    chk("rr_ra10", 32'(bus.req_ra), 32'h28);
    chk("rr_cmp10", 32'(bus.cmp_tid), 32'h3);
    step; bus.req_ack = 0;
    chk("rr_v11", 32'(bus.req_val), 32'h0);
    chk("rr_cval11", 32'(bus.cmp_val), 32'h1);
    chk("rr_cmp11", 32'(bus.cmp_tid), 32'h0);
    step;
    chk("rr_cval12", 32'(bus.cmp_val), 32'h0);
    chk("rr_rdy12", 32'(bus.core_rdy), 32'hf);

    // Flush: t3 stcx queued behind presented t0; flush both
    core(2'd0, 1'b0, 32'h0000_0040);
    step; core(2'd3, 1'b1, 32'h0000_0060);
    chk("fl_rtid1", 32'(bus.req_tid), 32'h0);
    step; bus.core_val = 0;
    bus.core_flush = 4'b1001;
    chk("fl_rtid2", 32'(bus.req_tid), 32'h0);
    chk("fl_rdy2",  32'(bus.core_rdy), 32'h6);
    step; bus.core_flush = 0;
    chk("fl_rdy3",  32'(bus.core_rdy), 32'he);
    chk("fl_rval3", 32'(bus.req_val), 32'h1);
    chk("fl_rtid3", 32'(bus.req_tid), 32'h0);
    bus.req_ack = 1;
    step; bus.req_ack = 0;
    chk("fl_rval4", 32'(bus.req_val), 32'h0);
    chk("fl_cval4", 32'(bus.cmp_val), 32'h1);
    chk("fl_ctid4", 32'(bus.cmp_tid), 32'h0);
    step;
    chk("fl_cval5", 32'(bus.cmp_val), 32'h0);
    chk("fl_rdy5",  32'(bus.core_rdy), 32'hf);

    // Collision: t0 larx ack and t1 stcx rsp on the same edge
    core(2'd1, 1'b1, 32'h0000_0080);
    step; bus.core_val = 0;
    chk("co_rtid1", 32'(bus.req_tid), 32'h1);
    bus.req_ack = 1;
    step; bus.req_ack = 0;
    core(2'd0, 1'b0, 32'h0000_00a0);
    step; bus.core_val = 0;
    chk("co_rtid3", 32'(bus.req_tid), 32'h0);
    bus.req_ack = 1;
    bus.rsp_val = 1; bus.rsp_tid = 1; bus.rsp_pass = 0;
    step; bus.req_ack = 0; bus.rsp_val = 0;
    chk("co_cval4", 32'(bus.cmp_val), 32'h1);
    chk("co_ctid4", 32'(bus.cmp_tid), 32'h0);
    chk("co_cop4",  32'(bus.cmp_op), 32'h0);
    step;
    chk("co_cval5", 32'(bus.cmp_val), 32'h1);
    chk("co_ctid5", 32'(bus.cmp_tid), 32'h1);
    chk("co_cop5",  32'(bus.cmp_op), 32'h1);
    chk("co_cpass5",32'(bus.cmp_pass), 32'h0);
    step;
    chk("co_cval6", 32'(bus.cmp_val), 32'h0);
    chk("co_err",   32'(bus.err), 32'h0);

    // Error: response to an IDLE thread
    bus.rsp_val = 1; bus.rsp_tid = 2; bus.rsp_pass = 1;
    step; bus.rsp_val = 0; bus.rsp_pass = 0;
    chk("er_err1", 32'(bus.err), 32'h1);
    chk("er_cval1", 32'(bus.cmp_val), 32'h0);
    step; step;
    chk("er_err3", 32'(bus.err), 32'h1);
    chk("er_cval3", 32'(bus.cmp_val), 32'h0);
    rst = 1'b0; #1;
    chk("er_rst", 32'(bus.err), 32'h0);
    rst = 1'b1;

    // Error: request to a busy thread is dropped
    step;
    core(2'd1, 1'b0, 32'h0000_0020);
    step;
    chk("dr_rtid", 32'(bus.req_tid), 32'h1);
    chk("dr_err0", 32'(bus.err), 32'h0);
    core(2'd1, 1'b1, 32'h0000_0fe0);
    bus.req_ack = 1;
    step; bus.core_val = 0; bus.req_ack = 0;
    chk("dr_err", 32'(bus.err), 32'h1);
    chk("dr_ctid", 32'(bus.cmp_tid), 32'h1);
    chk("dr_cop",  32'(bus.cmp_op), 32'h0);
    step;

    // Reset mid-stcx abandons it; later rsp sets err
    rst = 1'b0; #1; rst = 1'b1;
    step;
    core(2'd2, 1'b1, 32'h0000_0c00);
    step; bus.core_val = 0;
    bus.req_ack = 1;
    step; bus.req_ack = 0;
    chk("ab_rdy", 32'(bus.core_rdy[2]), 32'h0);
    rst = 1'b0; #1;
    chk("ab_rst_rdy", 32'(bus.core_rdy), 32'hf);
    rst = 1'b1;
    step;
    bus.rsp_val = 1; bus.rsp_tid = 2; bus.rsp_pass = 1;
    step; bus.rsp_val = 0; bus.rsp_pass = 0;
    chk("ab_err",  32'(bus.err), 32'h1);
    chk("ab_cval", 32'(bus.cmp_val), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/smp_resv_req.md
# smp_resv_req

Core-side initiator for the SMP larx/stcx reservation protocol. Accepts load-and-reserve (larx) and store-conditional (stcx) requests from up to four core threads and issues them one at a time to the SMP reservation fabric. It tracks one outstanding operation per thread, collects stcx pass/fail responses, and returns per-thread completions to the core. It sits between the core's load/store unit and the SMP fabric port.

## Interface
- `THREADS`, 4: thread count; the thread id is 2 bits wide.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `core_val`  in  1: core request valid.
- `core_tid`  in  2: requesting thread.
- `core_op`  in  1: 0 = larx, 1 = stcx.
- `core_ra`  in  32: real address; only bits 31:5 are used (32B granule).
- `core_rdy`  out  THREADS: per-thread ready. A thread is ready when its state is IDLE.
- `core_flush`  in  THREADS: per-thread flush.
- `req_val`  out  1: fabric request valid.
- `req_tid`  out  2: thread of the fabric request.
- `req_op`  out  1: operation of the fabric request.
- `req_ra`  out  27: granule address, bits 31:5.
- `req_ack`  in  1: fabric accepted the presented request.
- `rsp_val`  in  1: stcx response valid.
- `rsp_tid`  in  2: thread of the stcx response.
- `rsp_pass`  in  1: stcx result; 1 = store performed.
- `cmp_val`  out  1: completion valid to the core.
- `cmp_tid`  out  2: thread of the completion.
- `cmp_op`  out  1: operation of the completion.
- `cmp_pass`  out  1: stcx result; always 0 for larx.
- `err`  out  1: sticky protocol error.

## Operation
- Each thread has a state machine with states IDLE, REQ, WAIT and DONE. Each thread also holds registered op, ra[31:5] and pass.
- Accept: `core_val` with state[core_tid]=IDLE. The thread captures op and ra, and moves to REQ.
  - `core_val` to a thread that is not IDLE is dropped.
  - Dropping it is a core protocol violation: it sets `err`.
- Issue: round-robin arbitration among threads in REQ. The search starts at the thread after the last one acked.
  - Once `req_val` is asserted, tid, op and ra are held until `req_ack`. No re-arbitration happens while unacked.
- On `req_ack`:
  - larx: REQ->DONE. The fabric sets the reservation before reload, so larx needs no response.
  - stcx: REQ->WAIT.
  - The round-robin pointer moves to the thread after req_tid.
- On `rsp_val`:
  - If state[rsp_tid]=WAIT: capture `rsp_pass` and move WAIT->DONE.
  - In any other state the response is ignored and `err` is set.
- Completion: lowest-numbered thread in DONE drives `cmp_*`.
  - That thread moves DONE->IDLE on the same edge. There is no back-pressure from the core.
- Flush:
  - `core_flush[t]` with state REQ and t not currently presented on `req_*`: REQ->IDLE, no completion.
  - Flush in WAIT or DONE, or of the presented thread, is ignored. The operation is already committed to the fabric and completes normally.
- Reset: all threads IDLE, round-robin pointer 0, `err` cleared, captured op, ra and pass cleared.
  - Reset mid-operation abandons in-flight stcx. A later `rsp_val` for such a thread sets `err`.

## Timing
- Outputs `req_*`, `cmp_*` and `core_rdy` are decoded from registered state. There are no combinational paths from inputs to outputs.
- Reset values:
  - `core_rdy`=all ones.
  - `req_val`=0, `req_tid`=0, `req_op`=0, `req_ra`=0.
  - `cmp_val`=0, `cmp_tid`=0, `cmp_op`=0, `cmp_pass`=0.
  - `err`=0.
- larx minimum latency: accept at cycle 0, `req_val` at cycle 1, ack at cycle 1, `cmp_val` at cycle 2.
- stcx minimum latency: accept at cycle 0, req/ack at cycle 1, `rsp_val` at cycle 2, `cmp_val` at cycle 3.
- `rsp_val` for thread t in the same cycle as `req_ack` for thread t cannot occur, because t is still in REQ. It is ignored and sets `err`.
- Simultaneous `req_ack` (thread a) and `rsp_val` (thread b≠a): both transitions happen on the same edge.
- Multiple threads reaching DONE on one edge: they complete on consecutive cycles in ascending tid order.
- Flush and `core_val` for the same IDLE thread in the same cycle: the accept wins. Flush has no effect on IDLE.

## Test plan
- Reset check: assert `rst`=0 → `core_rdy`=4'b1111, all other outputs 0. Release reset, then larx tid 1, ra 0x0000_1040, ack immediate → `req_ra`=27'h82 at cycle 1; `cmp_val`=1, `cmp_tid`=1, `cmp_op`=0, `cmp_pass`=0 at cycle 2.
- Single stcx: stcx tid 2, ack at cycle 1, `rsp_val` tid 2 with pass=1 at cycle 4 → `cmp_val` at cycle 5 with `cmp_op`=1, `cmp_pass`=1. `core_rdy[2]`=0 over cycles 1–5 and 1 at cycle 6.
- Round-robin: larx on threads 0, 1, 2, 3 on consecutive cycles with `req_ack` held 0 for 5 cycles, then held 1 → `req_tid` stays 0 until acked, then issues 1, 2, 3 in order. A second request on thread 0 after it is acked issues after thread 3.
- Flush: stcx tid 3 queued behind presented tid 0, then `core_flush`=4'b1000 → tid 3 never appears on `req_*`, no completion, `core_rdy[3]`=1 next cycle. Flushing tid 0 while presented has no effect.
- Completion collision: tid 0 larx ack and tid 1 stcx rsp on the same edge → `cmp_tid`=0 then `cmp_tid`=1 on consecutive cycles.
- Error: `rsp_val` tid 2 while tid 2 is IDLE → `err`=1 next cycle, stays 1 until reset, no completion.
